udp_payload_buf: RTL and testbench
==================================

UDP_PAYLOAD_BUF -- requirements
Module: udp_payload_buf

Interface
REQ-001 Parameter AW, default 11, log2 of buffer depth in bytes (depth 2048).
REQ-002 Parameter MAX_LEN, default 1472, largest legal UDP payload in bytes.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_wr_data  input  8  payload byte from the data source.
REQ-006 i_wr_en  input  1  write strobe; one byte per cycle.
REQ-007 o_full  output  1  buffer holds 2^AW bytes.
REQ-008 o_overflow  output  1  sticky flag: a write was dropped.
REQ-009 i_ovf_clr  input  1  clears o_overflow.
REQ-010 i_frame_len  input  11  payload length of the next frame in bytes.
REQ-011 o_frame_avail  output  1  a complete frame is held and reserved for the packet generator.
REQ-012 i_rd_en  input  1  packet generator pulls one byte.
REQ-013 o_rd_data  output  8  byte read out.
REQ-014 o_rd_valid  output  1  o_rd_data is valid this cycle.
REQ-015 o_rd_last  output  1  marks the final byte of the frame.
REQ-016 i_abort  input  1  discards the remainder of the reserved frame.
REQ-017 o_level  output  AW+1  bytes currently stored.

Function
REQ-018 A write SHALL store i_wr_data at wr_ptr and advance wr_ptr modulo 2^AW when i_wr_en=1 and o_full=0.
REQ-019 A write with o_full=1 SHALL be dropped, leave every pointer unchanged, and set o_overflow on the next edge.
REQ-020 o_overflow SHALL clear on the next edge when i_ovf_clr=1, unless a dropped write occurs in the same cycle, in which case the set wins.
REQ-021 o_level SHALL count +1 per accepted write and -1 per read or discarded byte, with a simultaneous write and read leaving it unchanged; o_full = (o_level == 2^AW).
REQ-022 The FSM SHALL have two states: IDLE and READY.
REQ-023 IDLE->READY SHALL occur when 1 <= i_frame_len <= MAX_LEN and o_level >= i_frame_len, latching i_frame_len into rem_cnt; i_frame_len is ignored in READY.
REQ-024 In IDLE, a frame length of 0 or greater than MAX_LEN SHALL never start a frame.
REQ-025 o_frame_avail SHALL be 1 exactly while in READY, i.e. registered, first high on the cycle after the qualifying condition.
REQ-026 A read SHALL happen when the FSM is in READY, i_rd_en=1 and i_abort=0: it reads mem[rd_ptr], advances rd_ptr modulo 2^AW and decrements rem_cnt.
REQ-027 Read latency SHALL be 1 cycle: o_rd_data and o_rd_valid=1 are presented the cycle after i_rd_en.
REQ-028 Back-to-back i_rd_en SHALL yield one byte per cycle with no bubbles.
REQ-029 When rem_cnt=1 and a read occurs, o_rd_last SHALL accompany that byte and the FSM SHALL return to IDLE on the same edge.
REQ-030 After that final read, o_frame_avail SHALL be 0 in the cycle the last byte is presented.
REQ-031 i_rd_en in IDLE SHALL be ignored, with no pointer change and o_rd_valid=0.
REQ-032 i_abort in READY SHALL advance rd_ptr by rem_cnt and reduce o_level by rem_cnt in one cycle, then return to IDLE.
REQ-033 i_abort SHALL take priority over a simultaneous i_rd_en: no byte is output.
REQ-034 i_abort in IDLE SHALL be ignored.
REQ-035 Reads SHALL never pass unwritten data, since READY guarantees o_level >= rem_cnt.
REQ-036 A new frame MAY reach READY one cycle after the previous one ends, provided the level condition holds.
REQ-037 o_rd_valid and o_rd_last SHALL be 0 in all cycles without a preceding read.

Reset
REQ-038 While rst_n=0, wr_ptr, rd_ptr, rem_cnt and o_level SHALL be 0 and the FSM SHALL be in IDLE.
REQ-039 While rst_n=0, o_full, o_overflow, o_frame_avail, o_rd_valid, o_rd_last and o_rd_data SHALL be 0.
REQ-040 Buffer memory SHALL NOT be reset.
REQ-041 Reset asserted mid-frame SHALL abandon the frame and leave the buffer empty after release.

Verification
REQ-042 i_frame_len=4; write 01,02,03,04; pulse i_rd_en for 4 consecutive cycles -> o_frame_avail high 1 cycle after the 4th write; data 01..04 appear 1 cycle after each i_rd_en; o_rd_last only on 04; o_level returns to 0.
REQ-043 Write 2048 bytes, then a 2049th -> o_full=1; o_overflow=1; o_level=2048. Then i_ovf_clr -> o_overflow=0.
REQ-044 Wrap check: i_frame_len=1000; run 3 frames of incrementing data through 2048 bytes of buffer -> all 3000 bytes read back in order across the pointer wrap.
REQ-045 i_frame_len=10; 10 bytes written; read 3 bytes, then assert i_abort together with i_rd_en -> no 4th byte output; o_level=0; FSM in IDLE; next frame data correct.
REQ-046 i_frame_len=0, and separately 1473, with 100 bytes stored -> o_frame_avail stays 0.
REQ-047 Write and read in the same cycle at o_level=5 -> o_level remains 5.
REQ-048 Assert rst_n=0 mid-frame -> all outputs 0 and o_level=0 after release.

Source files
------------

// File: rtl/udp_payload_buf_if.sv
// Byte-stream write port and frame read port of the UDP payload buffer.
// master drives the inputs (source / packet generator), slave is the buffer.
interface udp_payload_buf_if #(
    parameter int unsigned AW = 11
);
    logic [7:0]  i_wr_data;
    logic        i_wr_en;
    logic        o_full;
    logic        o_overflow;
    logic        i_ovf_clr;
    logic [10:0] i_frame_len;
    logic        o_frame_avail;
    logic        i_rd_en;
    logic [7:0]  o_rd_data;
    logic        o_rd_valid;
    logic        o_rd_last;
    logic        i_abort;
    logic [AW:0] o_level;

    modport master (
        output i_wr_data, i_wr_en, i_ovf_clr, i_frame_len, i_rd_en, i_abort,
        input  o_full, o_overflow, o_frame_avail, o_rd_data, o_rd_valid, o_rd_last, o_level
    );

    modport slave (
        input  i_wr_data, i_wr_en, i_ovf_clr, i_frame_len, i_rd_en, i_abort,
        output o_full, o_overflow, o_frame_avail, o_rd_data, o_rd_valid, o_rd_last, o_level
    );
endinterface

// File: rtl/udp_payload_buf.sv
// Circular byte buffer that reserves one complete UDP payload frame at a time and
// streams it to the packet generator with 1-cycle read latency.
module udp_payload_buf #(
    parameter int unsigned AW      = 11,
    parameter int unsigned MAX_LEN = 1472
) (
    input logic               clk,
    input logic               rst_n,
    udp_payload_buf_if.slave  bus
);
    localparam int unsigned    DEPTH    = 1 << AW;
    localparam logic [AW:0]    LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    typedef enum logic {StIdle, StReady} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [10:0]   r_rem_cnt;
    logic          r_overflow;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_rd_last;
    state_t        r_state;

    state_t        w_state_d;
    logic          w_load;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;
    logic          w_ready;
    logic          w_rd;
    logic          w_abort;
    logic          w_start;
    logic          w_last_rd;
    logic [AW:0]   w_level_d;
    logic [AW-1:0] w_rd_ptr_d;

    assign w_full    = (r_level == LVL_FULL);
    assign w_wr      = bus.i_wr_en & ~w_full;
    assign w_drop    = bus.i_wr_en & w_full;
    assign w_ready   = (r_state == StReady);
    assign w_abort   = w_ready & bus.i_abort;
    assign w_rd      = w_ready & bus.i_rd_en & ~bus.i_abort;
    assign w_last_rd = w_rd & (r_rem_cnt == 11'd1);
    // A frame is only reserved once every one of its bytes is already stored.
    assign w_start   = (bus.i_frame_len != 11'd0)
                     && (32'(bus.i_frame_len) <= MAX_LEN)
                     && (32'(r_level) >= 32'(bus.i_frame_len));

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StReady;
                    w_load    = 1'b1;
                end
            end
            StReady: begin
                if (w_abort || w_last_rd) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_level_d  = r_level;
        w_rd_ptr_d = r_rd_ptr;
        if (w_wr) begin
            w_level_d = w_level_d + LVL_ONE;
        end
        if (w_rd) begin
            w_level_d  = w_level_d - LVL_ONE;
            w_rd_ptr_d = r_rd_ptr + PTR_ONE;
        end else if (w_abort) begin
            w_level_d  = w_level_d - (AW + 1)'(r_rem_cnt);
            w_rd_ptr_d = r_rd_ptr + AW'(r_rem_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rem_cnt  <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_level  <= w_level_d;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_load) begin
                r_rem_cnt <= bus.i_frame_len;
            end else if (w_rd) begin
                r_rem_cnt <= r_rem_cnt - 11'd1;
            end else if (w_abort) begin
                r_rem_cnt <= '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_rd_valid <= w_rd;
            r_rd_last  <= w_last_rd;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.o_full        = w_full;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_frame_avail = w_ready;
    assign bus.o_rd_data     = r_rd_data;
    assign bus.o_rd_valid    = r_rd_valid;
    assign bus.o_rd_last     = r_rd_last;
    assign bus.o_level       = r_level;
endmodule

// File: tb/tb_udp_payload_buf.sv
// Randomised and directed bench for udp_payload_buf against a queue-based frame model.
module tb_udp_payload_buf;
    localparam int AW      = 11;
    localparam int DEPTH   = 2048;
    localparam int MAX_LEN = 1472;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    udp_payload_buf_if #(.AW(AW)) bus ();

    udp_payload_buf #(.AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: stored bytes as a queue, plus the reservation of the current frame.
    byte unsigned q[$];
    bit           m_avail;
    int           m_rem;
    bit           m_ovf;
    bit           e_valid;
    bit           e_last;
    byte unsigned e_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic model_clear();
        q.delete();
        m_avail = 0;
        m_rem   = 0;
        m_ovf   = 0;
        e_valid = 0;
        e_last  = 0;
    endtask

    task automatic model_step();
        int  sz;
        int  flen;
        bit  rd;
        bit  ab;
        sz   = q.size();
        flen = int'(bus.i_frame_len);
        rd   = m_avail && bus.i_rd_en && !bus.i_abort;
        ab   = m_avail && bus.i_abort;
        e_valid = rd;
        e_last  = rd && (m_rem == 1);
        if (rd) begin
            e_data = q.pop_front();
            m_rem--;
            if (m_rem == 0) m_avail = 0;
        end else if (ab) begin
            repeat (m_rem) q.delete(0);
            m_rem   = 0;
            m_avail = 0;
        end else if (!m_avail && flen >= 1 && flen <= MAX_LEN && sz >= flen) begin
            m_avail = 1;
            m_rem   = flen;
        end
        if (bus.i_wr_en && sz < DEPTH) q.push_back(bus.i_wr_data);
        if (bus.i_wr_en && sz == DEPTH) m_ovf = 1;
        else if (bus.i_ovf_clr) m_ovf = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("rd_valid", bus.o_rd_valid, e_valid);
        check("rd_last", bus.o_rd_last, e_last);
        if (e_valid) check("rd_data", bus.o_rd_data, e_data);
        check("level", bus.o_level, q.size());
        check("full", bus.o_full, q.size() == DEPTH);
        check("overflow", bus.o_overflow, m_ovf);
        check("frame_avail", bus.o_frame_avail, m_avail);
    endtask

    task automatic idle_inputs();
        bus.i_wr_en   = 0;
        bus.i_rd_en   = 0;
        bus.i_abort   = 0;
        bus.i_ovf_clr = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, bus.o_full, 0);
        check({tag, "_ovf"}, bus.o_overflow, 0);
        check({tag, "_avail"}, bus.o_frame_avail, 0);
        check({tag, "_valid"}, bus.o_rd_valid, 0);
        check({tag, "_last"}, bus.o_rd_last, 0);
        check({tag, "_data"}, bus.o_rd_data, 0);
        check({tag, "_level"}, bus.o_level, 0);
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        bus.i_frame_len = 0;
        rst_n = 0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
        check_reset_outputs({tag, "_rel"});
    endtask

    task automatic write_bytes(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            bus.i_wr_en   = 1;
            bus.i_wr_data = 8'(start + i);
            cycle();
        end
        bus.i_wr_en = 0;
    endtask

    task automatic wait_avail();
        int t = 0;
        while (!m_avail && t < 10) begin
            cycle();
            t++;
        end
        if (!m_avail) check("avail_timeout", 0, 1);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_rd_en = 1;
            cycle();
        end
        bus.i_rd_en = 0;
    endtask

    initial begin
        int wcnt;
        int rcnt;
        int guard;
        byte unsigned exp_b;
        bus.i_wr_data = 0;
        model_clear();
        do_reset("rst0");

        // Single 4-byte frame.
        bus.i_frame_len = 4;
        write_bytes(4, 1);
        check("avail_after_4th_wr", bus.o_frame_avail, 0);
        cycle();
        check("avail_next_cycle", bus.o_frame_avail, 1);
        read_n(4);
        check("f4_last_seen", bus.o_rd_last, 1);
        check("f4_last_data", bus.o_rd_data, 8'h04);
        check("f4_level0", bus.o_level, 0);

        // Fill to full, one dropped write, then clear the flag.
        do_reset("rst1");
        write_bytes(DEPTH + 1, 0);
        check("full_set", bus.o_full, 1);
        check("ovf_set", bus.o_overflow, 1);
        check("level_2048", bus.o_level, 2048);
        bus.i_ovf_clr = 1;
        cycle();
        bus.i_ovf_clr = 0;
        check("ovf_cleared", bus.o_overflow, 0);

        // Three 1000-byte frames of incrementing data across the pointer wrap.
        do_reset("rst2");
        bus.i_frame_len = 1000;
        wcnt  = 0;
        rcnt  = 0;
        guard = 0;
        exp_b = 0;
        while (rcnt < 3000 && guard < 20000) begin
            bus.i_wr_en   = (wcnt < 3000) && ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
            bus.i_wr_data = 8'(wcnt);
            bus.i_rd_en   = $urandom_range(0, 1);
            if (bus.i_wr_en) wcnt++;
            cycle();
            if (e_valid) begin
                check("wrap_order", bus.o_rd_data, exp_b);
                exp_b++;
                rcnt++;
            end
            guard++;
        end
        idle_inputs();
        check("wrap_all_read", rcnt, 3000);

        // Abort after 3 of 10 bytes, with a simultaneous read request.
        do_reset("rst3");
        bus.i_frame_len = 10;
        write_bytes(10, 8'hA0);
        wait_avail();
        bus.i_frame_len = 0;
        read_n(3);
        check("abort_pre_data", bus.o_rd_data, 8'hA2);
        bus.i_abort = 1;
        bus.i_rd_en = 1;
        cycle();
        idle_inputs();
        check("abort_no_byte", bus.o_rd_valid, 0);
        check("abort_level0", bus.o_level, 0);
        check("abort_idle", bus.o_frame_avail, 0);
        bus.i_frame_len = 4;
        write_bytes(4, 8'h50);
        wait_avail();
        read_n(4);
        check("post_abort_last", bus.o_rd_data, 8'h53);

        // Illegal frame lengths never reserve a frame.
        do_reset("rst4");
        write_bytes(100, 0);
        repeat (5) cycle();
        check("len0_no_avail", bus.o_frame_avail, 0);
        bus.i_frame_len = 1473;
        repeat (5) cycle();
        check("len1473_no_avail", bus.o_frame_avail, 0);

        // Simultaneous write and read at level 5, then reset mid-frame.
        do_reset("rst5");
        write_bytes(5, 8'h10);
        bus.i_frame_len = 3;
        wait_avail();
        bus.i_wr_en   = 1;
        bus.i_wr_data = 8'h77;
        bus.i_rd_en   = 1;
        cycle();
        idle_inputs();
        check("level_stays_5", bus.o_level, 5);
        do_reset("rst_mid");
        repeat (3) cycle();
        check("mid_rst_level0", bus.o_level, 0);

        // Random traffic.
        do_reset("rst6");
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.i_frame_len = 0;
                    1: bus.i_frame_len = 11'($urandom_range(1, 64));
                    2: bus.i_frame_len = 11'(1473);
                    default: bus.i_frame_len = 11'($urandom_range(0, 2047));
                endcase
            end
            bus.i_wr_en   = $urandom_range(0, 99) < 60;
            bus.i_wr_data = 8'($urandom);
            bus.i_rd_en   = $urandom_range(0, 99) < 70;
            bus.i_abort   = $urandom_range(0, 99) < 2;
            bus.i_ovf_clr = $urandom_range(0, 99) < 5;
            cycle();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
